vram_arbiter: RTL and testbench

- Shares one single-port texture/frame RAM (VGA_SCREEN_SIZE x 32 bit, 1-cycle read latency) between two requesters.
  - The VGA pixel-fetch path: painter texture reads.
  - The CPU data-memory port: read/write.
- Pixel fetch has priority during active display. CPU has priority during blanking.
- A starvation timer guarantees CPU progress. Sits between the memory-mapped CPU bus, the RAM macro and the VGA painter, in the clk_25 domain.

---
 rtl/vram_arbiter_pkg.sv | 29 ++
 rtl/vram_wait_timer.sv | 50 +++++
 rtl/vram_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vram_arbiter_pkg
// Shared constants and types for the VRAM arbiter slice.
//   VGA_SCREEN_SIZE  number of 32-bit words in the texture/frame RAM
//   VRAM_ADDR_W      word address width derived from VGA_SCREEN_SIZE
//   MAX_WAIT_DEF     default CPU starvation limit in cycles
//   grant_t          which requester owns the RAM port this cycle
//   cpu_state_t      CPU access sequencer states
// -----------------------------------------------------------------------------
package vram_arbiter_pkg;

    localparam int VGA_SCREEN_SIZE = 4096;
    localparam int VRAM_ADDR_W     = $clog2(VGA_SCREEN_SIZE);
    localparam int MAX_WAIT_DEF    = 8;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_VGA,
        GNT_CPU
    } grant_t;

    typedef enum logic [1:0] {
        C_IDLE,
        C_ISSUE,
        C_CAPTURE,
        C_ACK
    } cpu_state_t;

endpackage

// File: rtl/vram_wait_timer.sv
// -----------------------------------------------------------------------------
// vram_wait_timer
// Saturating count of cycles the CPU has been eligible but denied the RAM.
//   clk, rst_n  clock and asynchronous active-low reset
//   eligible    CPU could take the port this cycle
//   granted     CPU took the port this cycle (clears the count)
//   clear       CPU is not requesting (clears the count)
//   expired     count has reached MAX_WAIT; next eligible cycle is forced
// -----------------------------------------------------------------------------
module vram_wait_timer
    import vram_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic eligible,
    input  logic granted,
    input  logic clear,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

    logic [7:0] cnt_q, cnt_d;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == LIMIT) ? v : v + 8'd1;
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        if (clear || granted) begin
            cnt_d = '0;
        end else if (eligible) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Shares one single-port VRAM (1-cycle read latency) between the VGA pixel
// fetch path and the CPU data port. VGA wins during active display, CPU wins
// during blanking, and a starvation timer forces a CPU grant after MAX_WAIT
// denied cycles.
//   clk, rst_n                        pixel clock, async active-low reset
//   in_blank                          high outside the display area
//   vga_req/vga_addr                  single-cycle pixel fetch request
//   vga_rdata/vga_rvalid/vga_miss     fetch result two cycles after request
//   cpu_req/cpu_we/cpu_addr/cpu_wdata CPU request, held until cpu_ack
//   cpu_rdata/cpu_ack                 CPU completion, 3 cycles after grant
//   mem_en/mem_we/mem_addr/mem_wdata  RAM port, driven combinationally
//   mem_rdata                         RAM read data, 1 cycle after access
// Optional build macro VRAM_ARB_STATS_EN adds stat_miss_cnt and
// stat_force_cnt (16-bit saturating counters of misses and forced grants).
// -----------------------------------------------------------------------------
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W   = VRAM_ADDR_W,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_blank,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    output logic              vga_miss,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_miss_cnt,
    output logic [15:0]       stat_force_cnt
`endif
);

    cpu_state_t        state_q, state_d;
    grant_t            grant;
    logic              cpu_elig;
    logic              expired;
    logic              cpu_we_q, cpu_we_d;
    logic              vga_tag_q, vga_tag_d;
    logic              miss_tag_q, miss_tag_d;
    logic              vga_rvalid_q, vga_rvalid_d;
    logic              vga_miss_q, vga_miss_d;
    logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;

    assign cpu_elig = (state_q == C_IDLE) && cpu_req;

    // Holding the grant at NONE while in reset keeps the RAM port quiet.
    always_comb begin
        grant = GNT_NONE;
        if (!rst_n) begin
            grant = GNT_NONE;
        end else if (cpu_elig && (expired || in_blank)) begin
            grant = GNT_CPU;
        end else if (vga_req) begin
            grant = GNT_VGA;
        end else if (cpu_elig) begin
            grant = GNT_CPU;
        end
    end

    always_comb begin
        mem_en    = (grant != GNT_NONE);
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (grant)
            GNT_CPU: begin
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            GNT_VGA: mem_addr = vga_addr;
            default: ;
        endcase
    end

    vram_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .eligible (cpu_elig),
        .granted  (grant == GNT_CPU),
        .clear    (!cpu_req),
        .expired  (expired)
    );

    always_comb begin
        // Stage 1 tags: what happened to the VGA request in this cycle.
        vga_tag_d    = (grant == GNT_VGA);
        miss_tag_d   = vga_req && (grant != GNT_VGA);
        // Stage 2: RAM data is valid now for accesses tagged last cycle.
        vga_rvalid_d = vga_tag_q;
        vga_miss_d   = miss_tag_q;
        vga_rdata_d  = vga_tag_q ? mem_rdata : vga_rdata_q;

        state_d     = state_q;
        cpu_we_d    = cpu_we_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ack_d   = 1'b0;
        case (state_q)
            C_IDLE: begin
                if (grant == GNT_CPU) begin
                    state_d  = C_ISSUE;
                    cpu_we_d = cpu_we;
                end
            end
            C_ISSUE: begin
                state_d = C_CAPTURE;
                if (!cpu_we_q) begin
                    cpu_rdata_d = mem_rdata;
                end
            end
            C_CAPTURE: begin
                state_d   = C_ACK;
                cpu_ack_d = 1'b1;
            end
            C_ACK:   state_d = C_IDLE;
            default: state_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= C_IDLE;
            cpu_we_q     <= 1'b0;
            vga_tag_q    <= 1'b0;
            miss_tag_q   <= 1'b0;
            vga_rvalid_q <= 1'b0;
            vga_miss_q   <= 1'b0;
            vga_rdata_q  <= '0;
            cpu_rdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpu_we_q     <= cpu_we_d;
            vga_tag_q    <= vga_tag_d;
            miss_tag_q   <= miss_tag_d;
            vga_rvalid_q <= vga_rvalid_d;
            vga_miss_q   <= vga_miss_d;
            vga_rdata_q  <= vga_rdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_ack_q    <= cpu_ack_d;
        end
    end

    assign vga_rdata  = vga_rdata_q;
    assign vga_rvalid = vga_rvalid_q;
    assign vga_miss   = vga_miss_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_ack    = cpu_ack_q;

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stat_miss_q, stat_miss_d;
    logic [15:0] stat_force_q, stat_force_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        stat_miss_d  = vga_miss_q ? sat_inc16(stat_miss_q) : stat_miss_q;
        // A CPU grant while the timer is expired can only come from the
        // forced-grant rule, since that rule is checked first.
        stat_force_d = ((grant == GNT_CPU) && expired) ? sat_inc16(stat_force_q)
                                                       : stat_force_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_miss_q  <= '0;
            stat_force_q <= '0;
        end else begin
            stat_miss_q  <= stat_miss_d;
            stat_force_q <= stat_force_d;
        end
    end

    assign stat_miss_cnt  = stat_miss_q;
    assign stat_force_cnt = stat_force_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

    localparam int AW       = 12;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 8;

    logic          clk;
    logic          rst_n;
    logic          in_blank;
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_rdata;
    logic          vga_rvalid;
    logic          vga_miss;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef VRAM_ARB_STATS_EN
    logic [15:0]   stat_miss_cnt;
    logic [15:0]   stat_force_cnt;
`endif

    vram_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_blank   (in_blank),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_rdata  (vga_rdata),
        .vga_rvalid (vga_rvalid),
        .vga_miss   (vga_miss),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef VRAM_ARB_STATS_EN
        ,
        .stat_miss_cnt  (stat_miss_cnt),
        .stat_force_cnt (stat_force_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port RAM with one cycle of read latency, preloaded with addr*3.
    logic [DW-1:0] ram [0:4095];
    initial begin
        mem_rdata = '0;
        for (int i = 0; i < 4096; i++) ram[i] = 32'(i * 3);
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) ram[mem_addr] = mem_wdata;
                else        mem_rdata <= ram[mem_addr];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Reference model: expected memory contents plus a schedule of output
    // events keyed by cycle number (ring of 8 slots).
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc_n    = 0;
    logic [DW-1:0] ref_mem [0:4095];
    bit            r_rv  [8];
    bit            r_ms  [8];
    bit            r_ack [8];
    bit            r_cu  [8];
    logic [DW-1:0] r_vd  [8];
    logic [DW-1:0] r_cd  [8];
    int            m_cnt;
    int            m_free_at;
    logic [DW-1:0] m_vrd;
    logic [DW-1:0] m_crd;
    int            n_rv, n_miss, n_ack;
    int            last_ack_cyc, last_miss_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            r_rv[i] = 0; r_ms[i] = 0; r_ack[i] = 0; r_cu[i] = 0;
            r_vd[i] = '0; r_cd[i] = '0;
        end
        m_cnt = 0; m_free_at = 0; m_vrd = '0; m_crd = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdata"},  64'(vga_rdata),  64'(0));
        chk({tag, "_rvalid"}, 64'(vga_rvalid), 64'(0));
        chk({tag, "_miss"},   64'(vga_miss),   64'(0));
        chk({tag, "_crdata"}, 64'(cpu_rdata),  64'(0));
        chk({tag, "_ack"},    64'(cpu_ack),    64'(0));
        chk({tag, "_men"},    64'(mem_en),     64'(0));
        chk({tag, "_mwe"},    64'(mem_we),     64'(0));
        chk({tag, "_maddr"},  64'(mem_addr),   64'(0));
        chk({tag, "_mwdata"}, 64'(mem_wdata),  64'(0));
`ifdef VRAM_ARB_STATS_EN
        chk({tag, "_smiss"},  64'(stat_miss_cnt),  64'(0));
        chk({tag, "_sforce"}, 64'(stat_force_cnt), 64'(0));
`endif
    endtask

    task automatic do_reset(input int hold);
        @(posedge clk); #1;
        rst_n = 1'b0;
        in_blank = 0; vga_req = 0; vga_addr = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        #1 chk_all_zero("rst_now");
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk_all_zero("rst_hold");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    // One clock cycle: drive inputs, check every output against the model,
    // then advance the model to the end of the cycle.
    task automatic cyc(input logic blank, input logic vreq, input logic [AW-1:0] vaddr,
                       input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                       input logic [DW-1:0] cwd);
        bit elig, g_cpu, g_vga, forced;
        int s, t;
        @(posedge clk); #1;
        in_blank = blank; vga_req = vreq; vga_addr = vaddr;
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        t      = cyc_n;
        elig   = creq && (t >= m_free_at);
        forced = elig && (m_cnt == MAX_WAIT);
        g_cpu  = elig && (forced || blank || !vreq);
        g_vga  = vreq && !g_cpu;

        @(negedge clk);
        chk("mem_en", 64'(mem_en), 64'(g_cpu || g_vga));
        if (g_cpu) begin
            chk("mem_we_cpu", 64'(mem_we), 64'(cwe));
            chk("mem_addr_cpu", 64'(mem_addr), 64'(caddr));
            if (cwe) chk("mem_wdata", 64'(mem_wdata), 64'(cwd));
        end else if (g_vga) begin
            chk("mem_we_vga", 64'(mem_we), 64'(0));
            chk("mem_addr_vga", 64'(mem_addr), 64'(vaddr));
        end else begin
            chk("mem_we_idle", 64'(mem_we), 64'(0));
        end
        s = t % 8;
        if (r_rv[s]) m_vrd = r_vd[s];
        if (r_cu[s]) m_crd = r_cd[s];
        chk("vga_rvalid", 64'(vga_rvalid), 64'(r_rv[s]));
        chk("vga_miss",   64'(vga_miss),   64'(r_ms[s]));
        chk("vga_rdata",  64'(vga_rdata),  64'(m_vrd));
        chk("cpu_ack",    64'(cpu_ack),    64'(r_ack[s]));
        chk("cpu_rdata",  64'(cpu_rdata),  64'(m_crd));
        r_rv[s] = 0; r_ms[s] = 0; r_ack[s] = 0; r_cu[s] = 0;

        if (vga_rvalid) n_rv++;
        if (vga_miss) begin n_miss++; last_miss_cyc = t; end
        if (cpu_ack)  begin n_ack++;  last_ack_cyc  = t; end

        if (g_vga) begin
            r_rv[(t + 2) % 8] = 1;
            r_vd[(t + 2) % 8] = ref_mem[vaddr];
        end
        if (vreq && !g_vga) r_ms[(t + 2) % 8] = 1;
        if (g_cpu) begin
            if (cwe) begin
                ref_mem[caddr] = cwd;
            end else begin
                r_cu[(t + 2) % 8] = 1;
                r_cd[(t + 2) % 8] = ref_mem[caddr];
            end
            r_ack[(t + 3) % 8] = 1;
            m_free_at = t + 4;
        end
        if (g_cpu || !creq)                 m_cnt = 0;
        else if (elig && m_cnt < MAX_WAIT)  m_cnt++;
        cyc_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 0, '0, '0);
    endtask

    task automatic starve(input logic [AW-1:0] caddr);
        int  s, m0;
        bit  got;
        got = 0;
        idle(3);
        s  = cyc_n;
        m0 = n_miss;
        for (int i = 0; i < 14; i++) begin
            cyc(0, 1, AW'(i), !got, 0, caddr, '0);
            if (cpu_ack) got = 1;
        end
        idle(3);
        chk("starve_ack_cycle",  64'(last_ack_cyc - s),  64'(11));
        chk("starve_miss_cycle", 64'(last_miss_cyc - s), 64'(10));
        chk("starve_miss_count", 64'(n_miss - m0),       64'(1));
    endtask

    initial begin : main
        int            s, rv0, ms0, ack0;
        bit            c_act;
        logic          blank, cwe;
        logic [AW-1:0] cad;
        logic [DW-1:0] cwd;

        rst_n = 1'b0;
        in_blank = 0; vga_req = 0; vga_addr = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        n_rv = 0; n_miss = 0; n_ack = 0; last_ack_cyc = -1; last_miss_cyc = -1;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 32'(i * 3);
        model_clear();
        do_reset(2);

        // VGA only: 16 back-to-back fetches of addresses 0..15.
        rv0 = n_rv; ms0 = n_miss;
        for (int i = 0; i < 16; i++) cyc(0, 1, AW'(i), 0, 0, '0, '0);
        idle(3);
        chk("vga_only_rvalid_count", 64'(n_rv - rv0),   64'(16));
        chk("vga_only_miss_count",   64'(n_miss - ms0), 64'(0));
        chk("vga_only_last_data",    64'(vga_rdata),    64'(45));

        // CPU write then read during blanking.
        s = cyc_n;
        for (int i = 0; i < 4; i++) cyc(1, 0, '0, 1, 1, 12'h123, 32'hDEADBEEF);
        chk("cpu_wr_ack_latency", 64'(last_ack_cyc - s), 64'(3));
        cyc(1, 0, '0, 0, 0, '0, '0);
        s = cyc_n;
        for (int i = 0; i < 4; i++) cyc(1, 0, '0, 1, 0, 12'h123, '0);
        chk("cpu_rd_ack_latency", 64'(last_ack_cyc - s), 64'(3));
        chk("cpu_rd_data",        64'(cpu_rdata),        64'(32'hDEADBEEF));
        idle(2);

        // Starvation under continuous pixel fetches.
        starve(12'h010);

        // Blank priority: CPU first, VGA the following cycle.
        s = cyc_n;
        cyc(1, 1, 12'h040, 1, 1, 12'h200, 32'hCAFEF00D);
        cyc(1, 1, 12'h041, 1, 1, 12'h200, 32'hCAFEF00D);
        chk("blank_vga_follow_en",   64'(mem_en),   64'(1));
        chk("blank_vga_follow_addr", 64'(mem_addr), 64'(12'h041));
        cyc(1, 0, '0, 1, 1, 12'h200, 32'hCAFEF00D);
        cyc(1, 0, '0, 1, 1, 12'h200, 32'hCAFEF00D);
        chk("blank_miss_cycle", 64'(last_miss_cyc - s), 64'(2));
        chk("blank_ack_cycle",  64'(last_ack_cyc - s),  64'(3));
        idle(2);

        // Reset in the cycle after a CPU read grant.
        cyc(1, 0, '0, 1, 0, 12'h123, '0);
        do_reset(2);
        rv0 = n_rv; ack0 = n_ack;
        idle(6);
        chk("post_reset_no_ack",    64'(n_ack - ack0), 64'(0));
        chk("post_reset_no_rvalid", 64'(n_rv - rv0),   64'(0));

        // Randomized traffic over a small address window to force collisions.
        c_act = 0; blank = 0; cwe = 0; cad = '0; cwd = '0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(15) == 0) blank = !blank;
            if (!c_act && $urandom_range(3) == 0) begin
                c_act = 1;
                cwe   = 1'($urandom_range(1));
                cad   = AW'($urandom_range(31));
                cwd   = $urandom;
            end
            cyc(blank, $urandom_range(9) < 8, AW'($urandom_range(31)), c_act, cwe, cad, cwd);
            if (c_act && cpu_ack) c_act = 0;
        end
        idle(4);

`ifdef VRAM_ARB_STATS_EN
        do_reset(1);
        starve(12'h011);
        starve(12'h012);
        starve(12'h013);
        chk("stat_force_cnt", 64'(stat_force_cnt), 64'(3));
        chk("stat_miss_cnt",  64'(stat_miss_cnt),  64'(3));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
